// File: rtl/iqmod_pkg.sv
// iqmod_pkg: shared default widths, FSM state, midscale helper and phase-dither LFSR constants
package iqmod_pkg;
  localparam int IQ_W_D = 8;
  localparam int TBL_AW_D = 8;
  localparam int TBL_DW_D = 8;
  localparam int PHASE_W_D = 24;
  localparam int DAC_W_D = 10;
  localparam int RATE_W_D = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [31:0] midscale(input int w);
    return 32'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/iqmod_sincos_lut.sv
// iqmod_sincos_lut: registered full-wave sin/cos ROM; cos is read a quarter turn ahead in the same table
module iqmod_sincos_lut #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic [AW-1:0]        addr,
  output logic signed [DW-1:0] sin_v,
  output logic signed [DW-1:0] cos_v
);
  localparam int N = 1 << AW;
  logic signed [DW-1:0] rom [N];
  function automatic logic signed [DW-1:0] sin_at(input int k);
    real v;
    v = real'((1 << (DW - 1)) - 1) * $sin(2.0 * 3.141592653589793 * k / N);
    return v < 0.0 ? DW'(-$rtoi(0.5 - v)) : DW'($rtoi(v + 0.5));
  endfunction
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = sin_at(k);
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sin_v <= '0;
      cos_v <= '0;
    end else begin
      sin_v <= rom[addr];
      cos_v <= rom[addr + AW'(N / 4)];
    end
  end
endmodule

// File: rtl/iqmod_nco.sv
// iqmod_nco: NCO IQ upconverter, I*cos - Q*sin to offset-binary DAC word.
// Optional phase dither below the LUT address with IQMOD_PHASE_DITHER_EN.
module iqmod_nco import iqmod_pkg::*; #(
  parameter int IQ_W    = IQ_W_D,
  parameter int TBL_AW  = TBL_AW_D,
  parameter int TBL_DW  = TBL_DW_D,
  parameter int PHASE_W = PHASE_W_D,
  parameter int DAC_W   = DAC_W_D,
  parameter int RATE_W  = RATE_W_D
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   enable,
  input  logic [PHASE_W-1:0]     fcw,
  input  logic [RATE_W-1:0]      rate,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IQ_W-1:0] i_in,
  input  logic signed [IQ_W-1:0] q_in,
  output logic [DAC_W-1:0]       dac_out,
  output logic                   underflow
);
  localparam int PW = IQ_W + TBL_DW;
  localparam int SW = PW + 1;
  localparam int SH = SW - DAC_W;
  state_t state;
  logic [PHASE_W-1:0] phase;
  logic [RATE_W-1:0] hold_cnt;
  logic pend_v, run, consume, accept;
  logic signed [IQ_W-1:0] pend_i, pend_q, act_i, act_q, s1_i, s1_q;
  logic signed [TBL_DW-1:0] sin_v, cos_v;
  logic signed [PW-1:0] pi, pq;
  logic signed [SW-1:0] sum;
  logic [TBL_AW-1:0] addr;
  assign run = state == RUN;
  assign consume = run && hold_cnt == '0;
  assign in_ready = !pend_v || consume;
  assign accept = in_valid && in_ready;
`ifdef IQMOD_PHASE_DITHER_EN
  localparam int DW = (PHASE_W - TBL_AW < 16) ? PHASE_W - TBL_AW : 16;
  localparam logic [15:0] DMASK = 16'((32'd1 << DW) - 1);
  logic [15:0] lfsr;
  logic [PHASE_W-1:0] phase_d;
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) lfsr <= LFSR_SEED;
    else if (run) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end
  // dither carries may ripple into the address; the accumulator itself is untouched
  assign phase_d = phase + PHASE_W'(lfsr & DMASK);
  assign addr = phase_d[PHASE_W-1 -: TBL_AW];
`else
  assign addr = phase[PHASE_W-1 -: TBL_AW];
`endif
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      phase <= '0;
      hold_cnt <= '0;
      pend_v <= 1'b0;
      pend_i <= '0;
      pend_q <= '0;
      act_i <= '0;
      act_q <= '0;
      underflow <= 1'b0;
    end else begin
      state <= enable ? RUN : IDLE;
      underflow <= consume && !pend_v;
      if (accept) begin
        pend_v <= 1'b1;
        pend_i <= i_in;
        pend_q <= q_in;
      end else if (consume) pend_v <= 1'b0;
      if (run) begin
        phase <= phase + fcw;
        hold_cnt <= consume ? rate : hold_cnt - RATE_W'(1);
        if (consume) begin
          act_i <= pend_v ? pend_i : '0;
          act_q <= pend_v ? pend_q : '0;
        end
      end else begin
        phase <= '0;
        hold_cnt <= '0;
        act_i <= '0;
        act_q <= '0;
      end
    end
  end
  iqmod_sincos_lut #(.AW(TBL_AW), .DW(TBL_DW)) u_lut (
    .clk(clk),
    .reset_(reset_),
    .addr(addr),
    .sin_v(sin_v),
    .cos_v(cos_v)
  );
  assign sum = SW'(pi) - SW'(pq);
  // samples entering S1 are gated by state so the flush to midscale starts on IDLE entry
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s1_i <= '0;
      s1_q <= '0;
      pi <= '0;
      pq <= '0;
      dac_out <= DAC_W'(midscale(DAC_W));
    end else begin
      s1_i <= run ? act_i : '0;
      s1_q <= run ? act_q : '0;
      pi <= PW'(s1_i) * PW'(cos_v);
      pq <= PW'(s1_q) * PW'(sin_v);
      dac_out <= DAC_W'(midscale(DAC_W)) + DAC_W'(sum >>> SH);
    end
  end
endmodule

// File: tb/tb_iqmod_nco.sv
// tb_iqmod_nco: scoreboard bench for iqmod_nco at default parameters, dither macro off
module tb_iqmod_nco;
  localparam real PI = 3.141592653589793;
  logic clk = 1'b0, reset_ = 1'b0, enable = 1'b0, in_valid = 1'b0;
  logic [23:0] fcw = '0;
  logic [7:0] rate = '0;
  logic signed [7:0] i_in = '0, q_in = '0;
  logic in_ready, underflow;
  logic [9:0] dac_out;
  int total = 0, bad = 0;
  int exp_q[$];
  bit m_run, m_pv, m_uf;
  int m_hold, m_pi, m_pq, m_ai, m_aq;
  int unsigned m_phase;
  int a_w[70], b_w[70];

  iqmod_nco dut (
    .clk(clk), .reset_(reset_), .enable(enable), .fcw(fcw), .rate(rate),
    .in_valid(in_valid), .in_ready(in_ready), .i_in(i_in), .q_in(q_in),
    .dac_out(dac_out), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rnd(input real v);
    return v < 0.0 ? -$rtoi($floor(0.5 - v)) : $rtoi($floor(v + 0.5));
  endfunction
  function automatic int sin_ref(input int k);
    return rnd(127.0 * $sin(2.0 * PI * k / 256.0));
  endfunction
  function automatic int cos_ref(input int k);
    return rnd(127.0 * $cos(2.0 * PI * k / 256.0));
  endfunction

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_uf = 0;
    m_hold = 0; m_pi = 0; m_pq = 0; m_ai = 0; m_aq = 0; m_phase = 0;
    exp_q = {512, 512, 512};
  endtask

  // advance the reference by one clock using the inputs the DUT just sampled
  task automatic model_step();
    bit cons, acc;
    int a, e;
    cons = m_run && m_hold == 0;
    acc = in_valid && (!m_pv || cons);
    m_uf = cons && !m_pv;
    if (m_run) begin
      if (cons) begin
        m_ai = m_pv ? m_pi : 0;
        m_aq = m_pv ? m_pq : 0;
        m_hold = rate;
      end else m_hold--;
      m_phase = (m_phase + fcw) & 32'hFF_FFFF;
    end else begin
      m_phase = 0; m_hold = 0; m_ai = 0; m_aq = 0;
    end
    if (acc) begin
      m_pv = 1; m_pi = i_in; m_pq = q_in;
    end else if (cons) m_pv = 0;
    m_run = enable;
    a = int'(m_phase >> 16);
    e = m_run ? m_ai * cos_ref(a) - m_aq * sin_ref(a) : 0;
    exp_q.push_back(512 + (e >>> 7));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("dac", dac_out, exp_q.pop_front());
    check("rdy", in_ready, (!m_pv || (m_run && m_hold == 0)) ? 1 : 0);
    check("uf", underflow, m_uf);
  endtask

  initial begin
    int n, mx, ufs, nrdy;
    #12;
    check("rst_dac", dac_out, 512);
    check("rst_rdy", in_ready, 1);
    check("rst_uf", underflow, 0);
    model_reset();
    reset_ = 1'b1;
    fcw = 24'd1 << 19;
    rate = 0;
    in_valid = 1; i_in = 127; q_in = 0;
    repeat (3) tick();
    enable = 1;
    for (int j = 0; j < 70; j++) begin
      tick();
      a_w[j] = dac_out;
    end
    mx = 0;
    for (int j = 0; j < 70; j++) if (a_w[j] > mx) mx = a_w[j];
    check("i_peak", mx, 638);
    check("i_first_mid", a_w[3], 512);
    check("i_first", a_w[4], 636);
    check("i_peak_at", a_w[35], 638);
    check("i_period", a_w[20], a_w[52]);
    enable = 0;
    repeat (5) tick();
    check("idle_mid", dac_out, 512);
    i_in = 0; q_in = 127;
    enable = 1;
    for (int j = 0; j < 70; j++) begin
      tick();
      b_w[j] = dac_out;
    end
    for (int j = 6; j <= 60; j += 6) check("q_shift", b_w[j], a_w[j + 8]);
    #2 reset_ = 1'b0;
    #1;
    check("mid_rst_dac", dac_out, 512);
    check("mid_rst_rdy", in_ready, 1);
    check("mid_rst_uf", underflow, 0);
    model_reset();
    enable = 0; in_valid = 0;
    #2 reset_ = 1'b1;
    rate = 3;
    in_valid = 1; i_in = 100; q_in = -50;
    tick();
    in_valid = 0;
    enable = 1;
    tick();
    tick();
    n = 0;
    while (!underflow && n < 10) begin
      tick();
      n++;
    end
    check("uf_gap", n, 4);
    repeat (3) tick();
    check("uf_dac", dac_out, 512);
    rate = 0;
    ufs = 0; nrdy = 0;
    for (int j = 0; j < 40; j++) begin
      in_valid = 1;
      i_in = 8'($urandom);
      q_in = 8'($urandom);
      tick();
      if (j >= 8) begin
        ufs += underflow;
        nrdy += !in_ready;
      end
    end
    check("s5_uf", ufs, 0);
    check("s5_rdy", nrdy, 0);
    enable = 0;
    repeat (4) tick();
    check("off_mid", dac_out, 512);
    enable = 1;
    for (int j = 0; j < 400; j++) begin
      in_valid = $urandom_range(0, 3) != 0;
      i_in = 8'($urandom);
      q_in = 8'($urandom);
      rate = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) fcw = 24'($urandom);
      if ($urandom_range(0, 39) == 0) enable = !enable;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
